// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: funct3 codes, FSM encoding,
// and access-size / alignment helpers.
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_D  = 3'b011;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;
  localparam logic [2:0] F3_WU = 3'b110;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD   = 3'd1,
    ST_RMW_RD = 3'd2,
    ST_WRITE  = 3'd3,
    ST_RESP   = 3'd4
  } lsu_state_e;

  // Access size in bytes; funct3[2] only selects zero-extension.
  function automatic logic [3:0] f3_size(input logic [2:0] f3);
    case (f3[1:0])
      2'b00:   return 4'd1;
      2'b01:   return 4'd2;
      2'b10:   return 4'd4;
      default: return 4'd8;
    endcase
  endfunction

  function automatic logic is_aligned(input logic [2:0] f3, input logic [2:0] lo);
    case (f3[1:0])
      2'b00:   return 1'b1;
      2'b01:   return ~lo[0];
      2'b10:   return (lo[1:0] == 2'b00);
      default: return (lo == 3'b000);
    endcase
  endfunction

  function automatic logic [2:0] force_align(input logic [2:0] f3, input logic [2:0] lo);
    case (f3[1:0])
      2'b00:   return lo;
      2'b01:   return {lo[2:1], 1'b0};
      2'b10:   return {lo[2], 2'b00};
      default: return 3'b000;
    endcase
  endfunction

  function automatic logic is_illegal(input logic is_store, input logic [2:0] f3);
    return is_store ? f3[2] : (f3 == 3'b111);
  endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Byte-lane steering: extends the addressed lane of a read word for loads and
// merges store bytes into an old doubleword for read-modify-write. Pure combinational.
module lsu_lane_align
  import lsu_pkg::*;
#(
  parameter int XLEN = 64
) (
  input  logic [2:0]      funct3_i,
  input  logic [2:0]      addr_lo_i,
  input  logic [XLEN-1:0] old_word_i,
  input  logic [XLEN-1:0] store_data_i,
  input  logic [XLEN-1:0] rd_word_i,
  output logic [XLEN-1:0] merged_o,
  output logic [XLEN-1:0] load_val_o
);

  logic [XLEN-1:0] shifted;
  logic [XLEN-1:0] st_shift;
  logic [3:0]      size;
  logic [3:0]      lo_ext;
  logic [3:0]      hi_ext;

  always_comb begin
    shifted    = rd_word_i >> {addr_lo_i, 3'b000};
    load_val_o = shifted;
    case (funct3_i)
      F3_B:    load_val_o = {{(XLEN-8){shifted[7]}},   shifted[7:0]};
      F3_H:    load_val_o = {{(XLEN-16){shifted[15]}}, shifted[15:0]};
      F3_W:    load_val_o = {{(XLEN-32){shifted[31]}}, shifted[31:0]};
      F3_BU:   load_val_o = {{(XLEN-8){1'b0}},  shifted[7:0]};
      F3_HU:   load_val_o = {{(XLEN-16){1'b0}}, shifted[15:0]};
      F3_WU:   load_val_o = {{(XLEN-32){1'b0}}, shifted[31:0]};
      default: load_val_o = shifted;
    endcase
  end

  // A byte lane takes store data when it falls in [lo, lo+size).
  always_comb begin
    st_shift = store_data_i << {addr_lo_i, 3'b000};
    size     = f3_size(funct3_i);
    lo_ext   = {1'b0, addr_lo_i};
    hi_ext   = lo_ext + size;
    merged_o = old_word_i;
    for (int i = 0; i < 8; i++) begin
      if ((4'(i) >= lo_ext) && (4'(i) < hi_ext)) begin
        merged_o[8*i +: 8] = st_shift[8*i +: 8];
      end
    end
  end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: converts one byte..doubleword request into doubleword memory
// accesses (read, read-modify-write or full write) and reports result or fault.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int XLEN        = 64,
  parameter bit CHECK_ALIGN = 1'b1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic            req_is_store,
  input  logic [2:0]      req_funct3,
  input  logic [XLEN-1:0] req_addr,
  input  logic [XLEN-1:0] req_wdata,
  output logic            resp_valid,
  output logic [XLEN-1:0] resp_rdata,
  output logic            resp_misalign,
  output logic            resp_illegal,
  output logic            mem_read,
  output logic            mem_write,
  output logic [XLEN-1:0] mem_addr,
  output logic [XLEN-1:0] mem_wdata,
  input  logic [XLEN-1:0] mem_rdata
);

  lsu_state_e      state_q, state_d;
  logic [2:0]      f3_q, f3_d;
  logic [XLEN-1:0] addr_q, addr_d;
  logic [XLEN-1:0] sdata_q, sdata_d;
  logic [XLEN-1:0] wdata_q, wdata_d;
  logic [XLEN-1:0] rdata_q, rdata_d;
  logic            mis_q, mis_d;
  logic            ill_q, ill_d;

  logic [XLEN-1:0] merged;
  logic [XLEN-1:0] load_val;
  logic [2:0]      req_lo;
  logic            req_ill;
  logic            req_mis;

  lsu_lane_align #(.XLEN(XLEN)) u_align (
    .funct3_i     (f3_q),
    .addr_lo_i    (addr_q[2:0]),
    .old_word_i   (mem_rdata),
    .store_data_i (sdata_q),
    .rd_word_i    (mem_rdata),
    .merged_o     (merged),
    .load_val_o   (load_val)
  );

  assign req_ill = is_illegal(req_is_store, req_funct3);
  assign req_mis = CHECK_ALIGN && !is_aligned(req_funct3, req_addr[2:0]);
  assign req_lo  = CHECK_ALIGN ? req_addr[2:0] : force_align(req_funct3, req_addr[2:0]);

  always_comb begin
    state_d = state_q;
    f3_d    = f3_q;
    addr_d  = addr_q;
    sdata_d = sdata_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    mis_d   = mis_q;
    ill_d   = ill_q;
    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          f3_d    = req_funct3;
          addr_d  = {req_addr[XLEN-1:3], req_lo};
          sdata_d = req_wdata;
          rdata_d = '0;
          mis_d   = 1'b0;
          ill_d   = 1'b0;
          if (req_ill) begin
            ill_d   = 1'b1;
            state_d = ST_RESP;
          end else if (req_mis) begin
            mis_d   = 1'b1;
            state_d = ST_RESP;
          end else if (!req_is_store) begin
            state_d = ST_LOAD;
          end else if (req_funct3[1:0] == 2'b11) begin
            wdata_d = req_wdata;
            state_d = ST_WRITE;
          end else begin
            state_d = ST_RMW_RD;
          end
        end
      end
      ST_LOAD: begin
        rdata_d = load_val;
        state_d = ST_RESP;
      end
      ST_RMW_RD: begin
        wdata_d = merged;
        state_d = ST_WRITE;
      end
      ST_WRITE: state_d = ST_RESP;
      ST_RESP:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      f3_q    <= '0;
      addr_q  <= '0;
      sdata_q <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      mis_q   <= 1'b0;
      ill_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      f3_q    <= f3_d;
      addr_q  <= addr_d;
      sdata_q <= sdata_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      mis_q   <= mis_d;
      ill_q   <= ill_d;
    end
  end

  // Strobes decode from state so an async reset removes them immediately.
  assign req_ready     = (state_q == ST_IDLE);
  assign resp_valid    = (state_q == ST_RESP);
  assign mem_read      = (state_q == ST_LOAD) || (state_q == ST_RMW_RD);
  assign mem_write     = (state_q == ST_WRITE);
  assign mem_addr      = {addr_q[XLEN-1:3], 3'b000};
  assign mem_wdata     = wdata_q;
  assign resp_rdata    = rdata_q;
  assign resp_misalign = mis_q;
  assign resp_illegal  = ill_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit with a doubleword memory model.
module tb_load_store_unit;

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_is_store;
  logic [2:0]  req_funct3;
  logic [63:0] req_addr;
  logic [63:0] req_wdata;
  logic        resp_valid;
  logic [63:0] resp_rdata;
  logic        resp_misalign;
  logic        resp_illegal;
  logic        mem_read;
  logic        mem_write;
  logic [63:0] mem_addr;
  logic [63:0] mem_wdata;
  logic [63:0] mem_rdata;

  logic [63:0] mem [0:7];
  logic [63:0] widx;

  typedef struct {
    logic [63:0] rdata;
    logic        mis;
    logic        ill;
  } exp_t;

  exp_t sb_q[$];
  int   tests = 0;
  int   fails = 0;

  load_store_unit #(.XLEN(64), .CHECK_ALIGN(1'b1)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_is_store  (req_is_store),
    .req_funct3    (req_funct3),
    .req_addr      (req_addr),
    .req_wdata     (req_wdata),
    .resp_valid    (resp_valid),
    .resp_rdata    (resp_rdata),
    .resp_misalign (resp_misalign),
    .resp_illegal  (resp_illegal),
    .mem_read      (mem_read),
    .mem_write     (mem_write),
    .mem_addr      (mem_addr),
    .mem_wdata     (mem_wdata),
    .mem_rdata     (mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb begin
    widx      = mem_addr >> 3;
    mem_rdata = (widx < 64'd8) ? mem[widx[2:0]] : 64'd0;
  end

  always @(posedge clk) begin
    if (mem_write && (widx < 64'd8)) mem[widx[2:0]] <= mem_wdata;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: pops one expectation per response pulse.
  always @(negedge clk) begin
    if (rst_n) begin
      if ((mem_read && mem_write) || ((req_ready || resp_valid) && (mem_read || mem_write))) begin
        tests++;
        fails++;
        $display("FAIL strobe_excl: read=%b write=%b ready=%b resp=%b",
                 mem_read, mem_write, req_ready, resp_valid);
      end
      if (resp_valid) begin
        if (sb_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_resp: got resp_valid=1 expected no response");
        end else begin
          exp_t e;
          e = sb_q.pop_front();
          chk("resp_rdata", resp_rdata, e.rdata);
          chk("resp_misalign", {63'd0, resp_misalign}, {63'd0, e.mis});
          chk("resp_illegal", {63'd0, resp_illegal}, {63'd0, e.ill});
        end
      end
    end
  end

  task automatic wait_ready();
    int w = 0;
    @(negedge clk);
    while (!req_ready && w < 20) begin
      @(negedge clk);
      w++;
    end
    if (!req_ready) chk("ready_timeout", {63'd0, req_ready}, 64'd1);
  endtask

  task automatic issue(input string name, input bit st, input logic [2:0] f3,
                       input logic [63:0] addr, input logic [63:0] wdata,
                       input logic [63:0] exp_rdata, input bit mis, input bit ill,
                       input int lat, input int nrd, input int nwr);
    exp_t e;
    int   l   = 0;
    int   rd  = 0;
    int   wr  = 0;
    bit   got = 0;
    wait_ready();
    req_valid    = 1'b1;
    req_is_store = st;
    req_funct3   = f3;
    req_addr     = addr;
    req_wdata    = wdata;
    e.rdata = exp_rdata;
    e.mis   = mis;
    e.ill   = ill;
    sb_q.push_back(e);
    @(posedge clk);
    #1 req_valid = 1'b0;
    while (!got && l < 10) begin
      @(negedge clk);
      l++;
      rd += int'(mem_read);
      wr += int'(mem_write);
      if (resp_valid) got = 1;
    end
    chk({name, "_latency"}, 64'(got ? l : -1), 64'(lat));
    chk({name, "_reads"}, 64'(rd), 64'(nrd));
    chk({name, "_writes"}, 64'(wr), 64'(nwr));
  endtask

  initial begin
    bit saw_wr;
    int rv;
    mem[0] = 64'd10; mem[1] = 64'd20; mem[2] = 64'd30; mem[3] = 64'd40;
    mem[4] = 64'd50; mem[5] = 64'd0;  mem[6] = 64'd0;  mem[7] = 64'd0;
    rst_n        = 1'b0;
    req_valid    = 1'b0;
    req_is_store = 1'b0;
    req_funct3   = 3'b000;
    req_addr     = 64'd0;
    req_wdata    = 64'd0;
    #12;
    chk("rst_ready", {63'd0, req_ready}, 64'd1);
    chk("rst_strobes", {60'd0, resp_valid, resp_misalign, resp_illegal, mem_read | mem_write}, 64'd0);
    chk("rst_rdata", resp_rdata, 64'd0);
    chk("rst_mem_addr", mem_addr, 64'd0);
    chk("rst_mem_wdata", mem_wdata, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    issue("ld_10",  1'b0, 3'b011, 64'h10, 64'd0, 64'd30, 1'b0, 1'b0, 2, 1, 0);

    issue("sb_09",  1'b1, 3'b000, 64'h09, 64'h80, 64'd0, 1'b0, 1'b0, 3, 1, 1);
    issue("lb_09",  1'b0, 3'b000, 64'h09, 64'd0, 64'hFFFF_FFFF_FFFF_FF80, 1'b0, 1'b0, 2, 1, 0);
    issue("lbu_09", 1'b0, 3'b100, 64'h09, 64'd0, 64'h80, 1'b0, 1'b0, 2, 1, 0);
    issue("ld_08",  1'b0, 3'b011, 64'h08, 64'd0, 64'h8014, 1'b0, 1'b0, 2, 1, 0);

    issue("sh_03",  1'b1, 3'b001, 64'h03, 64'h1234, 64'd0, 1'b1, 1'b0, 1, 0, 0);
    chk("mem0_after_misalign", mem[0], 64'd10);
    issue("lw_06",  1'b0, 3'b010, 64'h06, 64'd0, 64'd0, 1'b1, 1'b0, 1, 0, 0);

    issue("ld_f7",  1'b0, 3'b111, 64'h00, 64'd0, 64'd0, 1'b0, 1'b1, 1, 0, 0);
    issue("st_f4",  1'b1, 3'b100, 64'h00, 64'hFF, 64'd0, 1'b0, 1'b1, 1, 0, 0);
    issue("st_f4_mis", 1'b1, 3'b101, 64'h01, 64'hFF, 64'd0, 1'b0, 1'b1, 1, 0, 0);
    chk("mem0_after_illegal", mem[0], 64'd10);

    issue("sw_14",  1'b1, 3'b010, 64'h14, 64'hDEADBEEF, 64'd0, 1'b0, 1'b0, 3, 1, 1);
    chk("mem2_after_sw", mem[2], 64'hDEADBEEF_0000001E);
    issue("lw_14",  1'b0, 3'b010, 64'h14, 64'd0, 64'hFFFF_FFFF_DEAD_BEEF, 1'b0, 1'b0, 2, 1, 0);
    issue("lwu_14", 1'b0, 3'b110, 64'h14, 64'd0, 64'hDEADBEEF, 1'b0, 1'b0, 2, 1, 0);

    issue("sd_20",  1'b1, 3'b011, 64'h20, 64'h1122334455667788, 64'd0, 1'b0, 1'b0, 2, 0, 1);
    chk("mem4_after_sd", mem[4], 64'h1122334455667788);
    issue("lh_26",  1'b0, 3'b001, 64'h26, 64'd0, 64'h1122, 1'b0, 1'b0, 2, 1, 0);
    issue("lhu_22", 1'b0, 3'b101, 64'h22, 64'd0, 64'h5566, 1'b0, 1'b0, 2, 1, 0);
    issue("lb_20",  1'b0, 3'b000, 64'h20, 64'd0, 64'hFFFF_FFFF_FFFF_FF88, 1'b0, 1'b0, 2, 1, 0);
    issue("sh_1e",  1'b1, 3'b001, 64'h1E, 64'hA5A5_BEEF, 64'd0, 1'b0, 1'b0, 3, 1, 1);
    chk("mem3_after_sh", mem[3], 64'hBEEF_0000_0000_0028);

    // Reset while the write strobe is up: the write must not land.
    wait_ready();
    req_valid    = 1'b1;
    req_is_store = 1'b1;
    req_funct3   = 3'b000;
    req_addr     = 64'h18;
    req_wdata    = 64'hAA;
    @(posedge clk);
    #1 req_valid = 1'b0;
    saw_wr = 1'b0;
    for (int i = 0; i < 5 && !saw_wr; i++) begin
      @(negedge clk);
      if (mem_write) saw_wr = 1'b1;
    end
    chk("rst_mid_saw_write", {63'd0, saw_wr}, 64'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_mid_write_drop", {63'd0, mem_write}, 64'd0);
    @(posedge clk);
    #1;
    chk("rst_mid_mem3", mem[3], 64'hBEEF_0000_0000_0028);
    @(negedge clk);
    rst_n = 1'b1;
    rv = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      rv += int'(resp_valid);
    end
    chk("rst_mid_no_resp", 64'(rv), 64'd0);
    chk("rst_mid_ready", {63'd0, req_ready}, 64'd1);

    chk("sb_drained", 64'(sb_q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
